multimode_ff_bank: RTL and testbench

- Parametrised bank of WIDTH flip-flops. All bits share one run-time mode: JK, D, T or SR.
- Adds three things a single JK cell does not have:
  - clock enable, synchronous clear and parallel load;
  - per-bit change pulses and a sticky illegal-SR error;
  - a saturating change-event counter.
- Sits in the control/status path. It is the general storage element for flag registers and toggle banks.

---
 rtl/multimode_ff_pkg.sv | 46 ++++
 rtl/multimode_ff_bank_ff_cell.sv | 22 ++
 rtl/multimode_ff_bank.sv | 84 ++++++++
 tb/tb_multimode_ff_bank.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/multimode_ff_pkg.sv
// Shared mode encodings and the single-bit next-state rule for the multimode flip-flop bank.
package multimode_ff_pkg;

   localparam logic [1:0] MODE_JK = 2'b00;
   localparam logic [1:0] MODE_D  = 2'b01;
   localparam logic [1:0] MODE_T  = 2'b10;
   localparam logic [1:0] MODE_SR = 2'b11;

   typedef struct packed {
      logic q;
      logic illegal;
   } bit_nxt_t;

   // Next value of one bit. The illegal flag is raised only for S=R=1 in SR mode,
   // and in that case the bit holds.
   function automatic bit_nxt_t next_bit(input logic [1:0] mode,
                                         input logic       q,
                                         input logic       a,
                                         input logic       b);
      bit_nxt_t r;
      r.q       = q;
      r.illegal = 1'b0;
      case (mode)
         MODE_JK: begin
            case ({a, b})
               2'b01:   r.q = 1'b0;
               2'b10:   r.q = 1'b1;
               2'b11:   r.q = ~q;
               default: r.q = q;
            endcase
         end
         MODE_D:  r.q = a;
         MODE_T:  r.q = a ? ~q : q;
         default: begin
            case ({a, b})
               2'b10:   r.q = 1'b1;
               2'b01:   r.q = 1'b0;
               2'b11:   r.illegal = 1'b1;
               default: r.q = q;
            endcase
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/multimode_ff_bank_ff_cell.sv
// One bit of the bank: combinational mode-dependent next state plus illegal-SR flag.
module ff_cell
   import multimode_ff_pkg::*;
(
   input  logic [1:0] mode,
   input  logic       q,
   input  logic       a,
   input  logic       b,
   output logic       q_nxt,
   output logic       illegal
);

   bit_nxt_t nxt;

   // Evaluate the shared next-state rule for this bit.
   always_comb begin
      nxt     = next_bit(mode, q, a, b);
      q_nxt   = nxt.q;
      illegal = nxt.illegal;
   end

endmodule

// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH flip-flops sharing one run-time mode (JK/D/T/SR), with enable,
// synchronous clear, parallel load, change pulses, sticky SR error and a
// saturating change counter. All outputs are registered.
module multimode_ff_bank
   import multimode_ff_pkg::*;
#(
   parameter int                 WIDTH     = 8,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0,
   parameter int                 CNT_W     = 8
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             en,
   input  logic             sclr,
   input  logic             load,
   input  logic [WIDTH-1:0] ld_data,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] changed,
   output logic             err_sr,
   output logic [CNT_W-1:0] chg_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] q_upd;
   logic [WIDTH-1:0] bit_ill;
   logic [WIDTH-1:0] q_nxt;
   logic             err_set;
   logic             q_flip;

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      ff_cell u_cell (
         .mode    (mode),
         .q       (q[g]),
         .a       (a[g]),
         .b       (b[g]),
         .q_nxt   (q_upd[g]),
         .illegal (bit_ill[g])
      );
   end

   // Priority select of the next q: sclr, then load, then mode update, else hold.
   always_comb begin
      q_nxt = q;
      if (sclr)
         q_nxt = RESET_VAL;
      else if (load)
         q_nxt = ld_data;
      else if (en)
         q_nxt = q_upd;
   end

   // Error is only meaningful when the SR update is actually applied.
   always_comb begin
      err_set = en && !sclr && !load && (mode == MODE_SR) && (|bit_ill);
      q_flip  = (q_nxt != q);
   end

   // State, change pulses, sticky error and saturating event counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q       <= RESET_VAL;
         changed <= '0;
         err_sr  <= 1'b0;
         chg_cnt <= '0;
      end else begin
         q       <= q_nxt;
         changed <= q_nxt ^ q;
         if (err_set)
            err_sr <= 1'b1;
         else if (err_clr)
            err_sr <= 1'b0;
         if (sclr)
            chg_cnt <= '0;
         else if (q_flip && (chg_cnt != CNT_MAX))
            chg_cnt <= chg_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed bench for multimode_ff_bank with a behavioural reference model
// checked every falling edge, plus literal expectations.
module tb_multimode_ff_bank;

   localparam int W = 4;
   localparam int C = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [1:0]   mode = 2'b00;
   logic         en = 1'b0;
   logic         sclr = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] ld_data = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         err_clr = 1'b0;
   logic [W-1:0] q;
   logic [W-1:0] changed;
   logic         err_sr;
   logic [C-1:0] chg_cnt;

   int tests = 0;
   int fails = 0;

   multimode_ff_bank #(.WIDTH(W), .RESET_VAL(4'b0000), .CNT_W(C)) dut (
      .clk(clk), .reset(reset), .mode(mode), .en(en), .sclr(sclr), .load(load),
      .ld_data(ld_data), .a(a), .b(b), .err_clr(err_clr),
      .q(q), .changed(changed), .err_sr(err_sr), .chg_cnt(chg_cnt)
   );

   always #5 clk = ~clk;

   // Reference model state.
   int m_q, m_chg, m_cnt, m_err;
   int nq, ill;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q = 0; m_chg = 0; m_cnt = 0; m_err = 0;
      end else begin
         ill = 0;
         if (sclr) nq = 0;
         else if (load) nq = int'(ld_data);
         else if (!en) nq = m_q;
         else begin
            nq = 0;
            for (int i = 0; i < W; i++) begin
               int cur, s, r, nb;
               cur = (m_q >> i) & 1;
               s = int'(a[i]);
               r = int'(b[i]);
               nb = cur;
               if (mode == 2'd1) nb = s;
               else if (mode == 2'd2) nb = s ? 1 - cur : cur;
               else if (mode == 2'd0) begin
                  if (s == 1 && r == 1) nb = 1 - cur;
                  else if (s == 1) nb = 1;
                  else if (r == 1) nb = 0;
               end else begin
                  if (s == 1 && r == 1) ill = 1;
                  else if (s == 1) nb = 1;
                  else if (r == 1) nb = 0;
               end
               nq = nq + (nb << i);
            end
         end
         m_chg = nq ^ m_q;
         if (sclr) m_cnt = 0;
         else if (nq != m_q && m_cnt < (1 << C) - 1) m_cnt = m_cnt + 1;
         if (ill) m_err = 1;
         else if (err_clr) m_err = 0;
         m_q = nq;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Continuous comparison of all outputs against the model.
   always @(negedge clk) begin
      check("model_q", int'(q), m_q);
      check("model_changed", int'(changed), m_chg);
      check("model_err", int'(err_sr), m_err);
      check("model_cnt", int'(chg_cnt), m_cnt);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      en = 0; sclr = 0; load = 0; err_clr = 0; a = '0; b = '0;
   endtask

   initial begin
      step; step;
      reset = 1'b1;
      step;
      check("rst_q", int'(q), 0);
      check("rst_cnt", int'(chg_cnt), 0);

      // Dirty the state, then async reset mid-cycle.
      mode = 2'd3; en = 1; a = 4'b0100; b = 4'b0100;
      step;
      check("pre_err", int'(err_sr), 1);
      idle; load = 1; ld_data = 4'b1010;
      step;
      idle;
      check("pre_q", int'(q), 4'b1010);
      #2 reset = 1'b0;
      #1;
      check("async_q", int'(q), 0);
      check("async_changed", int'(changed), 0);
      check("async_err", int'(err_sr), 0);
      check("async_cnt", int'(chg_cnt), 0);
      #1 reset = 1'b1;
      step;

      // JK mode.
      mode = 2'd0; en = 1; a = 4'b1100; b = 4'b0110;
      step;
      check("jk1_q", int'(q), 4'b1100);
      a = 4'b1111; b = 4'b1111;
      step;
      check("jk2_q", int'(q), 4'b0011);
      check("jk2_changed", int'(changed), 4'b1111);
      check("jk2_cnt", int'(chg_cnt), 2);

      // T mode with counter saturation.
      idle; sclr = 1;
      step;
      check("t_sclr_cnt", int'(chg_cnt), 0);
      sclr = 0; mode = 2'd2; en = 1; a = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         step;
         check("t_q0", int'(q), (i % 2 == 0) ? 1 : 0);
      end
      check("t_sat_cnt", int'(chg_cnt), 7);

      // SR mode with illegal bit, then error clear.
      idle; sclr = 1;
      step;
      sclr = 0; mode = 2'd3; en = 1; a = 4'b0011; b = 4'b0010;
      step;
      check("sr_q", int'(q), 4'b0001);
      check("sr_err", int'(err_sr), 1);
      a = 4'b0000; b = 4'b0000; err_clr = 1;
      step;
      check("sr_clr_err", int'(err_sr), 0);
      check("sr_clr_q", int'(q), 4'b0001);
      a = 4'b1000; b = 4'b1000; err_clr = 1;
      step;
      check("sr_set_wins", int'(err_sr), 1);
      idle; sclr = 1;
      step;
      check("sclr_keeps_err", int'(err_sr), 1);

      // sclr beats load.
      idle; load = 1; ld_data = 4'b0101;
      step;
      check("ld_q", int'(q), 4'b0101);
      sclr = 1; load = 1; ld_data = 4'b1111;
      step;
      check("sclr_q", int'(q), 0);
      check("sclr_cnt", int'(chg_cnt), 0);
      check("sclr_changed", int'(changed), 4'b0101);

      // Enable low holds, load ignores enable.
      idle; mode = 2'd1; a = 4'b1111;
      step;
      check("hold_q", int'(q), 0);
      check("hold_changed", int'(changed), 0);
      load = 1; ld_data = 4'b1001;
      step;
      check("ld_noen_q", int'(q), 4'b1001);
      check("ld_noen_cnt", int'(chg_cnt), 1);

      // D mode with enable, mode switch each cycle.
      idle; mode = 2'd1; en = 1; a = 4'b0110;
      step;
      check("d_q", int'(q), 4'b0110);
      mode = 2'd2; a = 4'b1111;
      step;
      check("t_after_d_q", int'(q), 4'b1001);
      idle;
      step;
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
